// File: rtl/bus2wb_bridge.sv
// Bridge from the native request/grant bus to a Wishbone classic master.
// Latency: request sampled at edge 0, STB in cycle 1, ACK in cycle k, GNT in cycle k+1 (min 2).
// Backpressure: the native master holds REQ until GNT; Wishbone stalls by withholding ACK.
//
// Ports: i_CLK/i_RSTn (sync, active-low); native side i_CE, i_REQ, i_WE, i_RE, i_HB,
//        i_ADDR, i_WDATA -> o_RDATA, o_GNT, o_ERR; Wishbone side o_WB_ADDR, o_WB_DATA,
//        o_WB_WE, o_WB_SEL, o_WB_STB, o_WB_CYC <- i_WB_DATA, i_WB_ACK.
// Optional feature: define BUS2WB_TIMEOUT_EN to abort cycles that see no ACK within
//        TIMEOUT_CYCLES cycles (o_ERR pulses with GNT, o_RDATA = 32'hDEADBEEF).
module bus2wb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    input  logic                  i_CE,
    input  logic                  i_REQ,
    input  logic                  i_WE,
    input  logic                  i_RE,
    input  logic [1:0]            i_HB,
    input  logic [ADDR_WIDTH-1:0] i_ADDR,
    input  logic [31:0]           i_WDATA,
    output logic [31:0]           o_RDATA,
    output logic                  o_GNT,
    output logic                  o_ERR,
    output logic [ADDR_WIDTH-1:0] o_WB_ADDR,
    output logic [31:0]           o_WB_DATA,
    input  logic [31:0]           i_WB_DATA,
    output logic                  o_WB_WE,
    output logic [3:0]            o_WB_SEL,
    output logic                  o_WB_STB,
    output logic                  o_WB_CYC,
    input  logic                  i_WB_ACK
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("bus2wb_bridge: TIMEOUT_CYCLES must lie in 1..255");
    end

    typedef enum logic [1:0] {IDLE, CYCLE, RESP} state_t;

    state_t      state_q;
    logic [1:0]  size_q;     // access size of the transaction in flight
    logic [1:0]  lsb_q;      // byte offset used to pick the read lane

    logic        start;
    logic [3:0]  sel_d;
    logic [31:0] wdata_d;
    logic [31:0] rdata_d;

    assign start = i_CE & i_REQ & (i_WE | i_RE);

    // Lane enables and replicated write data from the incoming request.
    // Halfword ignores addr[0]; word ignores addr[1:0].
    always_comb begin
        sel_d   = 4'b1111;
        wdata_d = i_WDATA;
        case (i_HB)
            2'b00: begin
                sel_d   = 4'b0001 << i_ADDR[1:0];
                wdata_d = {4{i_WDATA[7:0]}};
            end
            2'b01: begin
                sel_d   = 4'b0011 << {i_ADDR[1], 1'b0};
                wdata_d = {2{i_WDATA[15:0]}};
            end
            default: ;
        endcase
    end

    // Read lane selection: shift the addressed lane down to bit 0, zero-extend.
    always_comb begin
        rdata_d = i_WB_DATA;
        case (size_q)
            2'b00:   rdata_d = {24'h0, i_WB_DATA[{lsb_q, 3'b000} +: 8]};
            2'b01:   rdata_d = {16'h0, i_WB_DATA[{lsb_q[1], 4'b0000} +: 16]};
            default: ;
        endcase
    end

`ifdef BUS2WB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q;       // CYCLE cycles elapsed without ACK
`else
    assign o_ERR = 1'b0;
`endif

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            state_q   <= IDLE;
            size_q    <= 2'b00;
            lsb_q     <= 2'b00;
            o_GNT     <= 1'b0;
            o_RDATA   <= 32'h0;
            o_WB_ADDR <= '0;
            o_WB_DATA <= 32'h0;
            o_WB_WE   <= 1'b0;
            o_WB_SEL  <= 4'h0;
            o_WB_STB  <= 1'b0;
            o_WB_CYC  <= 1'b0;
`ifdef BUS2WB_TIMEOUT_EN
            cnt_q     <= 8'h0;
            o_ERR     <= 1'b0;
`endif
        end else begin
            o_GNT <= 1'b0;
`ifdef BUS2WB_TIMEOUT_EN
            o_ERR <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= CYCLE;
                        size_q    <= i_HB;
                        lsb_q     <= i_ADDR[1:0];
                        o_WB_ADDR <= {i_ADDR[ADDR_WIDTH-1:2], 2'b00};
                        o_WB_DATA <= wdata_d;
                        o_WB_SEL  <= sel_d;
                        o_WB_WE   <= i_WE;   // write wins when both strobes are set
                        o_WB_CYC  <= 1'b1;
                        o_WB_STB  <= 1'b1;
`ifdef BUS2WB_TIMEOUT_EN
                        cnt_q     <= 8'h0;
`endif
                    end
                end
                CYCLE: begin
                    if (i_WB_ACK) begin
                        state_q  <= RESP;
                        o_RDATA  <= rdata_d;
                        o_GNT    <= 1'b1;
                        o_WB_CYC <= 1'b0;
                        o_WB_STB <= 1'b0;
                    end
`ifdef BUS2WB_TIMEOUT_EN
                    // Count reaches TIMEOUT_CYCLES on this cycle: STB has been up
                    // for exactly TIMEOUT_CYCLES cycles, so abort. A late ACK in
                    // this same cycle is taken by the branch above.
                    else if (cnt_q == TO_LAST) begin
                        state_q  <= RESP;
                        o_RDATA  <= 32'hDEADBEEF;
                        o_GNT    <= 1'b1;
                        o_ERR    <= 1'b1;
                        o_WB_CYC <= 1'b0;
                        o_WB_STB <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
`endif
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus2wb_bridge.sv
module tb_bus2wb_bridge;

    logic        clk;
    logic        i_RSTn, i_CE, i_REQ, i_WE, i_RE;
    logic [1:0]  i_HB;
    logic [31:0] i_ADDR, i_WDATA, o_RDATA;
    logic        o_GNT, o_ERR;
    logic [31:0] o_WB_ADDR, o_WB_DATA, i_WB_DATA;
    logic        o_WB_WE;
    logic [3:0]  o_WB_SEL;
    logic        o_WB_STB, o_WB_CYC, i_WB_ACK;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_rises = 0;
    logic cyc_prev = 1'b0;

    bus2wb_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .i_CLK(clk), .i_RSTn(i_RSTn), .i_CE(i_CE), .i_REQ(i_REQ),
        .i_WE(i_WE), .i_RE(i_RE), .i_HB(i_HB), .i_ADDR(i_ADDR),
        .i_WDATA(i_WDATA), .o_RDATA(o_RDATA), .o_GNT(o_GNT), .o_ERR(o_ERR),
        .o_WB_ADDR(o_WB_ADDR), .o_WB_DATA(o_WB_DATA), .i_WB_DATA(i_WB_DATA),
        .o_WB_WE(o_WB_WE), .o_WB_SEL(o_WB_SEL), .o_WB_STB(o_WB_STB),
        .o_WB_CYC(o_WB_CYC), .i_WB_ACK(i_WB_ACK)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count Wishbone cycle starts, sampled mid-cycle.
    always @(negedge clk) begin
        cyc_prev <= o_WB_CYC;
        if (o_WB_CYC && !cyc_prev) cyc_rises <= cyc_rises + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference behaviour: which byte lanes a native access touches, what the
    // slave sees on the data bus, and what the master gets back.
    function automatic void model(input logic [1:0] hb, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] sdata,
                                  output logic [3:0] sel, output logic [31:0] wbd,
                                  output logic [31:0] rd);
        int unsigned lane;
        int unsigned pair;
        lane = addr % 4;
        pair = (addr / 2) % 2;
        case (hb)
            2'b00: begin
                sel = 4'(1 << lane);
                wbd = (wdata & 32'hFF) * 32'h0101_0101;
                rd  = (sdata >> (8 * lane)) & 32'hFF;
            end
            2'b01: begin
                sel = 4'(3 << (2 * pair));
                wbd = (wdata & 32'hFFFF) * 32'h0001_0001;
                rd  = (sdata >> (16 * pair)) & 32'hFFFF;
            end
            default: begin
                sel = 4'hF;
                wbd = wdata;
                rd  = sdata;
            end
        endcase
    endfunction

    // Starts in an IDLE cycle (just after an edge); returns in the GNT cycle.
    task automatic txn(input bit we, input logic [1:0] hb, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] sdata,
                       input int waits, input string tag);
        logic [3:0]  esel;
        logic [31:0] ewd, erd;
        model(hb, addr, wdata, sdata, esel, ewd, erd);
        i_CE = 1'b1; i_REQ = 1'b1; i_WE = we; i_RE = !we;
        i_HB = hb; i_ADDR = addr; i_WDATA = wdata;
        @(posedge clk); #1;
        // Native inputs are don't-care once the cycle is under way.
        i_REQ = 1'($urandom); i_WE = 1'($urandom); i_RE = 1'($urandom);
        i_HB = 2'($urandom); i_ADDR = $urandom; i_WDATA = $urandom;
        for (int c = 0; c <= waits; c++) begin
            check({tag, ".cycstb"}, 32'({o_WB_CYC, o_WB_STB}), 32'h3);
            check({tag, ".addr"}, o_WB_ADDR, addr & 32'hFFFF_FFFC);
            check({tag, ".sel"}, 32'(o_WB_SEL), 32'(esel));
            check({tag, ".we"}, 32'(o_WB_WE), 32'(we));
            if (we) check({tag, ".wdat"}, o_WB_DATA, ewd);
            check({tag, ".gnt_early"}, 32'(o_GNT), 32'h0);
            if (c == waits) begin
                i_WB_ACK = 1'b1;
                i_WB_DATA = sdata;
            end
            @(posedge clk); #1;
        end
        i_WB_ACK = 1'b0; i_WB_DATA = $urandom; i_REQ = 1'b0;
        check({tag, ".gnt"}, 32'(o_GNT), 32'h1);
        check({tag, ".err"}, 32'(o_ERR), 32'h0);
        check({tag, ".cyc_off"}, 32'({o_WB_CYC, o_WB_STB}), 32'h0);
        if (!we) check({tag, ".rdata"}, o_RDATA, erd);
    endtask

    // The cycle after GNT (or any idle cycle): stray ACKs must do nothing.
    task automatic idle_cycle(input string tag);
        i_WB_ACK = 1'($urandom);
        @(posedge clk); #1;
        i_WB_ACK = 1'b0;
        check({tag, ".idle_gnt"}, 32'(o_GNT), 32'h0);
        check({tag, ".idle_cyc"}, 32'(o_WB_CYC), 32'h0);
    endtask

    initial begin
        int c0;
        bit seen_gnt;
        bit seen_drop;
        i_RSTn = 1'b0; i_CE = 1'b0; i_REQ = 1'b0; i_WE = 1'b0; i_RE = 1'b0;
        i_HB = 2'b00; i_ADDR = '0; i_WDATA = '0; i_WB_DATA = '0; i_WB_ACK = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.gnt", 32'(o_GNT), 32'h0);
        check("rst.err", 32'(o_ERR), 32'h0);
        check("rst.cycstbwe", 32'({o_WB_CYC, o_WB_STB, o_WB_WE}), 32'h0);
        check("rst.sel", 32'(o_WB_SEL), 32'h0);
        check("rst.rdata", o_RDATA, 32'h0);
        check("rst.wbaddr", o_WB_ADDR, 32'h0);
        check("rst.wbdata", o_WB_DATA, 32'h0);
        i_RSTn = 1'b1;

        // Directed cases.
        txn(1'b0, 2'b10, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, "word_rd");
        idle_cycle("word_rd");
        txn(1'b1, 2'b00, 32'h0000_1003, 32'h0000_00A5, 32'h0, 3, "byte_wr");
        idle_cycle("byte_wr");
        txn(1'b0, 2'b01, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 1, "half_rd");
        idle_cycle("half_rd");

        // Back-to-back: request kept high with a new address through GNT.
        c0 = cyc_rises;
        txn(1'b0, 2'b10, 32'h0000_0100, 32'h0, 32'hCAFE_0001, 0, "b2b_a");
        i_CE = 1'b1; i_REQ = 1'b1; i_WE = 1'b0; i_RE = 1'b1; i_HB = 2'b10; i_ADDR = 32'h0000_0200;
        idle_cycle("b2b_gap");
        txn(1'b0, 2'b10, 32'h0000_0200, 32'h0, 32'hCAFE_0002, 0, "b2b_b");
        idle_cycle("b2b_b");
        check("b2b.cyc_count", 32'(cyc_rises - c0), 32'h2);

        // Reset pulse in the middle of a cycle.
        i_CE = 1'b1; i_REQ = 1'b1; i_WE = 1'b1; i_RE = 1'b0; i_HB = 2'b10;
        i_ADDR = 32'h0000_0040; i_WDATA = 32'h1111_2222;
        @(posedge clk); #1;
        i_REQ = 1'b0;
        check("rstmid.cyc_on", 32'(o_WB_CYC), 32'h1);
        i_RSTn = 1'b0;
        @(posedge clk); #1;
        i_RSTn = 1'b1;
        check("rstmid.cycstb", 32'({o_WB_CYC, o_WB_STB}), 32'h0);
        check("rstmid.gnt", 32'(o_GNT), 32'h0);
        i_WB_ACK = 1'b1;
        seen_gnt = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (o_GNT || o_WB_CYC) seen_gnt = 1'b1;
        end
        i_WB_ACK = 1'b0;
        check("rstmid.late_ack", 32'(seen_gnt), 32'h0);
        txn(1'b0, 2'b00, 32'h0000_0041, 32'h0, 32'h0000_7700, 2, "rstmid_next");
        idle_cycle("rstmid_next");

        // No ACK at all.
        i_CE = 1'b1; i_REQ = 1'b1; i_WE = 1'b0; i_RE = 1'b1; i_HB = 2'b10; i_ADDR = 32'h0000_0080;
        @(posedge clk); #1;
        i_REQ = 1'b0;
`ifdef BUS2WB_TIMEOUT_EN
        seen_drop = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (!o_WB_CYC || o_GNT) seen_drop = 1'b1;
            @(posedge clk); #1;
        end
        check("tmo.held4", 32'(seen_drop), 32'h0);
        check("tmo.cyc_off", 32'({o_WB_CYC, o_WB_STB}), 32'h0);
        check("tmo.gnt", 32'(o_GNT), 32'h1);
        check("tmo.err", 32'(o_ERR), 32'h1);
        check("tmo.rdata", o_RDATA, 32'hDEAD_BEEF);
        idle_cycle("tmo");
        check("tmo.err_pulse", 32'(o_ERR), 32'h0);
`else
        seen_drop = 1'b0;
        seen_gnt = 1'b0;
        repeat (300) begin
            @(posedge clk); #1;
            if (!o_WB_CYC || !o_WB_STB) seen_drop = 1'b1;
            if (o_GNT || o_ERR) seen_gnt = 1'b1;
        end
        check("notmo.cyc_held", 32'(seen_drop), 32'h0);
        check("notmo.no_gnt", 32'(seen_gnt), 32'h0);
        i_WB_ACK = 1'b1; i_WB_DATA = 32'h0BAD_F00D;
        @(posedge clk); #1;
        i_WB_ACK = 1'b0;
        check("notmo.gnt", 32'(o_GNT), 32'h1);
        check("notmo.err", 32'(o_ERR), 32'h0);
        check("notmo.rdata", o_RDATA, 32'h0BAD_F00D);
        idle_cycle("notmo");
`endif

        // Randomized traffic, with idle noise that must not start a cycle.
        for (int i = 0; i < 150; i++) begin
            bit          we;
            logic [1:0]  hb;
            logic [31:0] addr, wd, sd;
            int          waits;
            int          gap;
            we = 1'($urandom); hb = 2'($urandom); addr = $urandom;
            wd = $urandom; sd = $urandom; waits = $urandom_range(0, 3);
            txn(we, hb, addr, wd, sd, waits, "rand");
            gap = $urandom_range(0, 3);
            if (gap == 0) begin
                // Keep a request up through RESP; it must wait for IDLE.
                i_CE = 1'b1; i_REQ = 1'b1; i_RE = 1'b1;
            end
            idle_cycle("rand");
            for (int g = 1; g < gap; g++) begin
                case ($urandom_range(0, 2))
                    0: begin i_CE = 1'b1; i_REQ = 1'b0; i_WE = 1'b1; i_RE = 1'b1; end
                    1: begin i_CE = 1'b0; i_REQ = 1'b1; i_WE = 1'b1; i_RE = 1'b1; end
                    default: begin i_CE = 1'b1; i_REQ = 1'b1; i_WE = 1'b0; i_RE = 1'b0; end
                endcase
                idle_cycle("rand_gap");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus2wb_bridge.md
BUS2WB_BRIDGE -- requirements
Module: bus2wb_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of native bus address and Wishbone address.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum Wishbone cycles awaiting ACK; range 1..255.
REQ-003 i_CLK  input  1  single clock; all state updates on rising edge.
REQ-004 i_RSTn  input  1  reset; synchronous and active-low.
REQ-005 i_CE  input  1  native bus chip enable from address decode.
REQ-006 i_REQ  input  1  native bus request; held by the master until o_GNT.
REQ-007 i_WE / i_RE  input  1 each  native write / read strobes.
REQ-008 i_HB  input  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-009 i_ADDR  input  ADDR_WIDTH  native byte address.
REQ-010 i_WDATA  input  32  write data, right-justified.
REQ-011 o_RDATA  output  32  read data, right-justified, zero-extended.
REQ-012 o_GNT  output  1  one-cycle completion pulse.
REQ-013 o_ERR  output  1  one-cycle timeout flag, coincident with o_GNT.
REQ-014 o_WB_ADDR / o_WB_DATA / i_WB_DATA  ADDR_WIDTH / 32 / 32  Wishbone address, write data, read data.
REQ-015 o_WB_WE, o_WB_SEL[3:0], o_WB_STB, o_WB_CYC  output; i_WB_ACK  input  Wishbone classic master controls.

Function
REQ-016 FSM states: IDLE, CYCLE, RESP.
REQ-017 IDLE: when i_CE & i_REQ & (i_WE | i_RE), register address, size, write data and direction; go to CYCLE. i_WE takes priority if both are set.
REQ-018 CYCLE: o_WB_CYC = o_WB_STB = 1 and all Wishbone outputs stable until the cycle in which i_WB_ACK = 1; on that edge, capture i_WB_DATA and go to RESP.
REQ-019 RESP: o_GNT = 1 for exactly one cycle with o_RDATA valid; o_WB_CYC = o_WB_STB = 0; then return to IDLE.
REQ-020 Latency: request sampled at edge 0, STB high in cycle 1, ACK in cycle k (k>=1), GNT in cycle k+1; minimum latency 2 cycles.
REQ-021 A request still present in the cycle after GNT is treated as a new transaction.
REQ-022 o_WB_ADDR = {addr[ADDR_WIDTH-1:2], 2'b00}.
REQ-023 o_WB_SEL: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111.
REQ-024 o_WB_DATA: byte lane replicated x4; halfword replicated x2; word as-is.
REQ-025 o_RDATA: selected lane shifted to bit 0 and zero-extended; word as-is; held until the next RESP.
REQ-026 Misaligned halfword or word: addr[0] (halfword) or addr[1:0] (word) is ignored.
REQ-027 i_WB_ACK outside CYCLE is ignored.
REQ-028 Changes on native inputs during CYCLE or RESP are ignored.

Reset
REQ-029 While i_RSTn = 0 at a rising edge: state IDLE; o_GNT, o_ERR, o_WB_CYC, o_WB_STB, o_WB_WE = 0; o_WB_SEL = 0; o_RDATA, o_WB_ADDR, o_WB_DATA = 0.
REQ-030 Reset asserted mid-CYCLE drops CYC/STB at that edge; no GNT is issued for the aborted transaction.

Configuration
REQ-031 Macro BUS2WB_TIMEOUT_EN defined: an 8-bit counter clears on entry to CYCLE and increments each CYCLE cycle without ACK. At count == TIMEOUT_CYCLES, the bridge drops CYC/STB, enters RESP with o_RDATA = 32'hDEADBEEF and o_ERR = 1. ACK in that same cycle wins, with no error.
REQ-032 Macro undefined: no counter; CYCLE waits indefinitely; o_ERR tied to 0.

Verification
REQ-033 Word read at 0x0000_0010; slave ACKs in STB's first cycle with 0x1234_5678 -> WB_ADDR 0x10, SEL 1111, GNT in cycle 2, o_RDATA 0x1234_5678.
REQ-034 Byte write 0xA5 at addr 0x...03; ACK after 3 wait cycles -> SEL 1000, WB_DATA 0xA5A5_A5A5, WE 1, GNT exactly one cycle after ACK.
REQ-035 Halfword read at addr 0x...02; slave data 0xBEEF_0000 -> SEL 1100, o_RDATA 0x0000_BEEF.
REQ-036 Back-to-back: REQ held high with a new address after GNT -> second transaction starts in IDLE on the next edge; exactly two CYC assertions are seen.
REQ-037 i_RSTn low for 1 cycle mid-CYCLE -> CYC/STB low next cycle, no GNT, a later ACK is ignored, and the next request completes normally.
REQ-038 With BUS2WB_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ACK -> CYC drops after 4 cycles, GNT and ERR pulse, o_RDATA 0xDEADBEEF. Without the macro, CYC stays high after 300 cycles.
